// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the framed serial receiver.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DATA    = 3'd1,
    ST_PARITY  = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } rx_state_e;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  localparam int DEFAULT_DATA_W     = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/serial_rx_fifo.sv
// Synchronous output queue for received words. Read data is taken straight
// from the read pointer (no read latency). A push while full is accepted only
// when a pop happens in the same cycle; a pop while empty is ignored.
module serial_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push_s, do_pop_s;

  assign empty   = (count_q == {CNT_W{1'b0}});
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Qualify push/pop and compute next pointers and occupancy.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);

    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and storage registers; storage cleared so out_data resets to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, DATA_W data bits LSB-first, optional
// even parity bit, stop bit. Good words are queued in serial_rx_fifo.
// Build option: define SERIAL_RX_PARITY_EN to include the parity bit/check.
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        serial_in,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef SERIAL_RX_PARITY_EN
  // Even parity over the data word: 1 when the word has an odd number of ones.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_bad_q, par_bad_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              overrun_q, overrun_d;
  logic              push_s, pop_s, full_s, empty_s;

  assign pop_s      = out_ready && !empty_s;
  assign out_valid  = !empty_s;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

  // Next-state, shift/counter and error-pulse logic for the frame FSM.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    par_bad_d    = par_bad_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;
    push_s       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (serial_in == START_LEVEL) begin
          state_d   = ST_DATA;
          cnt_d     = '0;
          shift_d   = '0;
          par_bad_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        shift_d = shift_q | (DATA_W'(serial_in) << cnt_q);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      ST_PARITY: begin
        par_bad_d    = even_parity(shift_q) ^ serial_in;
        parity_err_d = even_parity(shift_q) ^ serial_in;
        state_d      = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (serial_in == LINE_IDLE) begin
          state_d = ST_IDLE;
          if (par_bad_q) begin
            push_s = 1'b0;
          end else if (full_s && !pop_s) begin
            overrun_d = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        // A line stuck low after a bad stop bit must not look like a new start.
        if (serial_in == LINE_IDLE) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RECOVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, shift/counter and registered error pulse state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      par_bad_q    <= par_bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  serial_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .wr_data (shift_q),
    .pop     (pop_s),
    .rd_data (out_data),
    .full    (full_s),
    .empty   (empty_s),
    .count   (fifo_count)
  );

endmodule
